pn_dac_source: RTL

Pseudo-noise and test-pattern sample source driving the 10-bit dual-channel DAC pin interface (data, DCLKIO, I/Q select). Sits directly upstream of the DAC pins and downstream of the processor-controlled configuration registers. Produces one sample per programmable period: PN15 bit, PN15 word, ramp or midscale. Supports clean start and stop so the DAC always parks at midscale.

---
 rtl/pn_dac_source.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pn_dac_source.sv
// PN15 / test-pattern sample source for a 10-bit dual-channel DAC pin interface.
// Emits one sample per programmable period and always parks the DAC at midscale when stopped.
module pn_dac_source #(
   parameter int LFSR_W = 15,
   parameter int DATA_W = 10,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic [LFSR_W-1:0] seed,
   input  logic              seed_load,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_dclkio,
   output logic              dac_iq,
   output logic              sample_stb,
   output logic              seq_wrap,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

   localparam int                CNT_W     = DIV_W + 1;
   localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [LFSR_W-1:0] STEP_LAST = {{(LFSR_W-1){1'b1}}, 1'b0};
   localparam logic [LFSR_W-1:0] SEED_ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_n;
   logic [LFSR_W-1:0] r_lfsr;
   logic [LFSR_W-1:0] r_step;
   logic [DATA_W-1:0] r_ramp;
   logic              r_pend;
   logic [LFSR_W-1:0] r_pend_seed;
   logic [DATA_W-1:0] r_data;
   logic              r_dclk;
   logic              r_iq;
   logic              r_stb;
   logic              r_wrap;

   logic [CNT_W-1:0]  w_n;
   logic              w_last;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_dclk_cur;
   logic              w_pend;
   logic [LFSR_W-1:0] w_pend_seed;
   logic [LFSR_W-1:0] w_seed_fix;
   logic [LFSR_W-1:0] w_lfsr_step;
   logic [LFSR_W-1:0] w_lfsr_nxt;
   logic [DATA_W-1:0] w_sample;

   assign w_n        = (rate_div == '0) ? CNT_W'(2) : CNT_W'(rate_div) + CNT_W'(1);
   assign w_last     = (r_cnt == r_n - CNT_W'(1));
   assign w_cnt_inc  = w_last ? '0 : r_cnt + CNT_W'(1);
   assign w_dclk_cur = (r_cnt < (r_n >> 1));

   // A load arriving in the boundary cycle itself is consumed by that boundary.
   assign w_pend      = r_pend | seed_load;
   assign w_pend_seed = seed_load ? seed : r_pend_seed;
   assign w_seed_fix  = (w_pend_seed == '0) ? SEED_ONE : w_pend_seed;
   assign w_lfsr_step = {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_W-1] ^ r_lfsr[LFSR_W-2]};
   assign w_lfsr_nxt  = w_pend ? w_seed_fix : w_lfsr_step;

   always_comb begin
      w_sample = MIDSCALE;
      unique case (mode)
         2'b00:   w_sample = {DATA_W{w_lfsr_nxt[LFSR_W-1]}};
         2'b01:   w_sample = w_lfsr_nxt[LFSR_W-1 -: DATA_W];
         2'b10:   w_sample = r_ramp;
         default: w_sample = MIDSCALE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_n         <= CNT_W'(2);
         r_lfsr      <= SEED_ONE;
         r_step      <= '0;
         r_ramp      <= '0;
         r_pend      <= 1'b0;
         r_pend_seed <= '0;
         r_data      <= MIDSCALE;
         r_dclk      <= 1'b0;
         r_iq        <= 1'b1;
         r_stb       <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_stb  <= 1'b0;
         r_wrap <= 1'b0;
         if (seed_load && r_state != S_IDLE) begin
            r_pend      <= 1'b1;
            r_pend_seed <= seed;
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_pend) begin
                  r_lfsr <= w_seed_fix;
                  r_step <= '0;
                  r_pend <= 1'b0;
               end
               if (enable) r_state <= S_PRIME;
            end
            S_PRIME: begin
               r_cnt   <= '0;
               r_ramp  <= '0;
               r_step  <= '0;
               r_iq    <= 1'b1;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (r_cnt == '0 && !enable) begin
                  r_state <= S_IDLE;
                  r_data  <= MIDSCALE;
                  r_dclk  <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_n    <= w_n;
                  r_cnt  <= CNT_W'(1);
                  r_dclk <= 1'b1;  // N >= 2, so phase 0 is always in the high half
                  r_lfsr <= w_lfsr_nxt;
                  r_pend <= 1'b0;
                  r_data <= w_sample;
                  r_iq   <= ~r_iq;
                  r_stb  <= 1'b1;
                  if (mode == 2'b10) r_ramp <= r_ramp + DATA_W'(1);
                  if (w_pend) begin
                     r_step <= '0;
                  end else if (r_step == STEP_LAST) begin
                     r_step <= '0;
                     r_wrap <= 1'b1;
                  end else begin
                     r_step <= r_step + LFSR_W'(1);
                  end
               end else begin
                  r_cnt  <= w_cnt_inc;
                  r_dclk <= w_dclk_cur;
                  if (!enable) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!enable && w_last) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_data  <= MIDSCALE;
                  r_dclk  <= 1'b0;
               end else begin
                  r_cnt  <= w_cnt_inc;
                  r_dclk <= w_dclk_cur;
                  if (enable) r_state <= S_RUN;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dac_data   = r_data;
   assign dac_dclkio = r_dclk;
   assign dac_iq     = r_iq;
   assign sample_stb = r_stb;
   assign seq_wrap   = r_wrap;
   assign busy       = (r_state != S_IDLE);

endmodule
